// File: rtl/zero_fill_unit_pkg.sv
// zero_fill_unit_pkg: width constants and registered-stage mode encodings
package zero_fill_unit_pkg;
  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  typedef enum logic [1:0] {
    ZF_LO = 2'b00,
    SEXT  = 2'b01,
    ZF_HI = 2'b10,
    RSVD  = 2'b11
  } zf_mode_e;
endpackage

// File: rtl/zero_fill_unit_ext.sv
// zero_fill_ext: combinational mode-selected 16->32 extension
// Sign extension exists only when ZERO_FILL_SEXT_EN is defined; otherwise SEXT acts as ZF_LO.
module zero_fill_ext
  import zero_fill_unit_pkg::*;
(
  input  logic [IN_W-1:0]  i_in,
  input  logic [1:0]       i_mode,
  output logic [OUT_W-1:0] o_ext
);
  logic [OUT_W-1:0] w_lo;
  logic [OUT_W-1:0] w_hi;
  assign w_lo = {{(OUT_W-IN_W){1'b0}}, i_in};
  assign w_hi = {i_in, {(OUT_W-IN_W){1'b0}}};
`ifdef ZERO_FILL_SEXT_EN
  logic [OUT_W-1:0] w_sext;
  assign w_sext = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};
  assign o_ext  = i_mode == ZF_HI ? w_hi : i_mode == SEXT ? w_sext : w_lo;
`else
  assign o_ext  = i_mode == ZF_HI ? w_hi : w_lo;
`endif
endmodule

// File: rtl/zero_fill_unit.sv
// zero_fill_unit: combinational zero-fill plus registered mode-selectable extension stage
// Optional sign-extend mode enabled by ZERO_FILL_SEXT_EN.
module zero_fill_unit #(
  parameter int IN_W  = zero_fill_unit_pkg::IN_W,
  parameter int OUT_W = zero_fill_unit_pkg::OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  In,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] Out,
  output logic [OUT_W-1:0] out_r,
  output logic             out_valid,
  output logic [15:0]      ext_count
);
  import zero_fill_unit_pkg::*;
  logic [OUT_W-1:0] w_ext;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic [15:0]      r_count;
  assign Out = {{(OUT_W-IN_W){1'b0}}, In};
  zero_fill_ext u_ext (
    .i_in  (In),
    .i_mode(mode),
    .o_ext (w_ext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_out   <= w_ext;
        r_count <= r_count + 16'd1;
      end
    end
  end
  assign out_r     = r_out;
  assign out_valid = r_valid;
  assign ext_count = r_count;
endmodule

// File: tb/tb_zero_fill_unit.sv
// tb_zero_fill_unit: directed-vector self-checking bench for zero_fill_unit
module tb_zero_fill_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] In;
  logic        in_valid;
  logic [1:0]  mode;
  logic [31:0] Out;
  logic [31:0] out_r;
  logic        out_valid;
  logic [15:0] ext_count;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_sext;

  zero_fill_unit dut (
    .clk      (clk),
    .rst      (rst),
    .In       (In),
    .in_valid (in_valid),
    .mode     (mode),
    .Out      (Out),
    .out_r    (out_r),
    .out_valid(out_valid),
    .ext_count(ext_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef ZERO_FILL_SEXT_EN
    exp_sext = 32'hFFFF8001;
`else
    exp_sext = 32'h00008001;
`endif
    rst = 1'b1; in_valid = 1'b0; mode = 2'b00; In = 16'hdcab;
    #1 chk("comb_dcab", Out, 32'h0000dcab);
    In = 16'h0123;
    #1 chk("comb_0123", Out, 32'h00000123);
    tick();
    tick();
    chk("rst_out_r", out_r, 32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_count", {16'b0, ext_count}, 32'h0);
    chk("comb_in_rst", Out, 32'h00000123);
    rst = 1'b0; in_valid = 1'b1; mode = 2'b00; In = 16'h8001;
    tick();
    chk("zf_lo", out_r, 32'h00008001);
    chk("zf_lo_valid", {31'b0, out_valid}, 32'h1);
    chk("zf_lo_count", {16'b0, ext_count}, 32'h1);
    mode = 2'b01;
    tick();
    chk("sext", out_r, exp_sext);
    chk("sext_count", {16'b0, ext_count}, 32'h2);
    mode = 2'b10; In = 16'h1234;
    tick();
    chk("zf_hi", out_r, 32'h12340000);
    mode = 2'b11;
    tick();
    chk("rsvd", out_r, 32'h00001234);
    chk("rsvd_count", {16'b0, ext_count}, 32'h4);
    in_valid = 1'b0; In = 16'hbeef;
    tick();
    chk("idle_valid", {31'b0, out_valid}, 32'h0);
    chk("idle_hold", out_r, 32'h00001234);
    chk("idle_count", {16'b0, ext_count}, 32'h4);
    chk("comb_beef", Out, 32'h0000beef);
    rst = 1'b1; in_valid = 1'b1; mode = 2'b00; In = 16'hffff;
    tick();
    chk("rstpri_valid", {31'b0, out_valid}, 32'h0);
    chk("rstpri_count", {16'b0, ext_count}, 32'h0);
    chk("rstpri_out_r", out_r, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      In = i[15:0];
      tick();
    end
    chk("pre_wrap_count", {16'b0, ext_count}, 32'h0000ffff);
    chk("pre_wrap_out_r", out_r, 32'h0000fffe);
    In = 16'h4242;
    tick();
    chk("wrap_count", {16'b0, ext_count}, 32'h0);
    chk("wrap_valid", {31'b0, out_valid}, 32'h1);
    in_valid = 1'b0;
    tick();
    chk("wrap_hold", {16'b0, ext_count}, 32'h0);
    chk("wrap_out_hold", out_r, 32'h00004242);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
